// File: rtl/temporizador_magnetron.sv
// Microwave cook timer: four BCD digits (mm:ss) entered from the keypad,
// magnetron enable latch, and a once-per-second countdown while running.
module temporizador_magnetron #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       set,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] digit,
    output logic       mag_on,
    output logic       timer_done,
    output logic       done_pulse,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StReady, StRun} state_e;

    state_e        state_q, state_d;
    logic [3:0]    mt_q, mu_q, st_q, su_q;
    logic [3:0]    mt_d, mu_d, st_d, su_d;
    logic [3:0]    mt_dec, mu_dec, st_dec, su_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic          mag_on_q, done_pulse_q, done_pulse_d;
    logic          tick, dec_zero, load_ok, load_zero;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign dec_zero  = ({mt_dec, mu_dec, st_dec, su_dec} == 16'h0000);
    // A seconds-units digit above 5 would become an illegal seconds-tens digit.
    assign load_ok   = (digit <= 4'd9) && (su_q <= 4'd5);
    assign load_zero = ({mu_q, st_q, su_q, digit} == 16'h0000);

    // One-second BCD decrement with borrow chain su -> st -> mu -> mt.
    always_comb begin
        mt_dec = mt_q;
        mu_dec = mu_q;
        st_dec = st_q;
        su_dec = su_q;
        if (su_q != 4'd0) begin
            su_dec = su_q - 4'd1;
        end else begin
            su_dec = 4'd9;
            if (st_q != 4'd0) begin
                st_dec = st_q - 4'd1;
            end else begin
                st_dec = 4'd5;
                if (mu_q != 4'd0) begin
                    mu_dec = mu_q - 4'd1;
                end else begin
                    mu_dec = 4'd9;
                    mt_dec = mt_q - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mt_d         = mt_q;
        mu_d         = mu_q;
        st_d         = st_q;
        su_d         = su_q;
        presc_d      = '0;
        done_pulse_d = 1'b0;
        if (clear) begin
            {mt_d, mu_d, st_d, su_d} = 16'h0000;
            state_d = StIdle;
        end else if (reset) begin
            if (state_q == StRun) state_d = StReady;
        end else if (state_q == StRun) begin
            if (tick) begin
                {mt_d, mu_d, st_d, su_d} = {mt_dec, mu_dec, st_dec, su_dec};
                if (dec_zero) begin
                    state_d      = StIdle;
                    done_pulse_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (set) begin
            if (state_q == StReady) state_d = StRun;
        end else if (load && load_ok) begin
            {mt_d, mu_d, st_d, su_d} = {mu_q, st_q, su_q, digit};
            state_d = load_zero ? StIdle : StReady;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            mt_q         <= '0;
            mu_q         <= '0;
            st_q         <= '0;
            su_q         <= '0;
            presc_q      <= '0;
            mag_on_q     <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mt_q         <= mt_d;
            mu_q         <= mu_d;
            st_q         <= st_d;
            su_q         <= su_d;
            presc_q      <= presc_d;
            mag_on_q     <= (state_d == StRun);
            done_pulse_q <= done_pulse_d;
        end
    end

    assign mag_on     = mag_on_q;
    assign done_pulse = done_pulse_q;
    assign timer_done = ({mt_q, mu_q, st_q, su_q} == 16'h0000);
    assign min_tens   = mt_q;
    assign min_units  = mu_q;
    assign sec_tens   = st_q;
    assign sec_units  = su_q;

endmodule

// File: tb/tb_temporizador_magnetron.sv
// Scoreboard bench for temporizador_magnetron: a seconds-based reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_temporizador_magnetron;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       set = 1'b0, reset = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on, timer_done, done_pulse;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;

    temporizador_magnetron #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .set        (set),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .digit      (digit),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .done_pulse (done_pulse),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .sec_tens   (sec_tens),
        .sec_units  (sec_units)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mag;
        logic        tdone;
        logic        dp;
        logic [15:0] t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   dp_seen = 0;

    // Reference model: time as four decimal digits, arithmetic done in seconds.
    int m_d[4];
    bit m_run;
    int m_phase;

    function automatic int m_secs();
        return (m_d[0] * 10 + m_d[1]) * 60 + m_d[2] * 10 + m_d[3];
    endfunction

    function automatic void m_from_secs(int s);
        int mm = s / 60;
        int ss = s % 60;
        m_d[0] = mm / 10;
        m_d[1] = mm % 10;
        m_d[2] = ss / 10;
        m_d[3] = ss % 10;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_run   = 0;
        m_phase = 0;
    endfunction

    function automatic exp_t m_step(bit s, bit r, bit c, bit l, int dg);
        exp_t e;
        bit   dp = 0;
        if (c) begin
            m_reset();
        end else if (r) begin
            m_run   = 0;
            m_phase = 0;
        end else if (m_run) begin
            if (m_phase == TD - 1) begin
                m_phase = 0;
                m_from_secs(m_secs() - 1);
                if (m_secs() == 0) begin
                    m_run = 0;
                    dp    = 1;
                end
            end else begin
                m_phase++;
            end
        end else if (s) begin
            if (m_secs() != 0) begin
                m_run   = 1;
                m_phase = 0;
            end
        end else if (l && dg <= 9 && m_d[3] <= 5) begin
            m_d[0] = m_d[1];
            m_d[1] = m_d[2];
            m_d[2] = m_d[3];
            m_d[3] = dg;
        end
        e.mag   = m_run;
        e.tdone = (m_secs() == 0);
        e.dp    = dp;
        e.t     = {m_d[0][3:0], m_d[1][3:0], m_d[2][3:0], m_d[3][3:0]};
        return e;
    endfunction

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("mag_on", int'(mag_on), int'(mon_e.mag));
            check("timer_done", int'(timer_done), int'(mon_e.tdone));
            check("done_pulse", int'(done_pulse), int'(mon_e.dp));
            check("time", int'({min_tens, min_units, sec_tens, sec_units}), int'(mon_e.t));
            if (done_pulse) dp_seen++;
        end
    end

    task automatic cyc(bit s, bit r, bit c, bit l, logic [3:0] dg);
        @(negedge clk);
        #1;
        set   = s;
        reset = r;
        clear = c;
        load  = l;
        digit = dg;
        @(posedge clk);
        q.push_back(m_step(s, r, c, l, int'(dg)));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0);
    endtask

    task automatic ld(logic [3:0] dg);
        cyc(0, 0, 0, 1, dg);
    endtask

    task automatic expect_time(string name, logic [15:0] t);
        #1;
        check(name, int'({min_tens, min_units, sec_tens, sec_units}), int'(t));
    endtask

    int base;

    initial begin
        m_reset();
        #2;
        check("rst_mag_on", int'(mag_on), 0);
        check("rst_timer_done", int'(timer_done), 1);
        check("rst_time", int'({min_tens, min_units, sec_tens, sec_units}), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Keypad entry 1,3,0 -> 01:30, not running.
        ld(4'd1); ld(4'd3); ld(4'd0);
        expect_time("load_0130", 16'h0130);
        check("load_mag_off", int'(mag_on), 0);

        // 00:03 countdown to natural expiry.
        cyc(0, 0, 1, 0, 0); ld(4'd3);
        base = dp_seen;
        cyc(1, 0, 0, 0, 0);
        idle(13);
        check("single_done_pulse", dp_seen - base, 1);

        // Borrow chains.
        cyc(0, 0, 1, 0, 0); ld(4'd1); ld(4'd0); ld(4'd0);
        cyc(1, 0, 0, 0, 0); idle(4);
        expect_time("borrow_0059", 16'h0059);
        cyc(0, 0, 1, 0, 0); ld(4'd1); ld(4'd0); ld(4'd0); ld(4'd0);
        cyc(1, 0, 0, 0, 0); idle(4);
        expect_time("borrow_0959", 16'h0959);

        // Pause and resume restarts the second.
        cyc(0, 0, 1, 0, 0); ld(4'd1); ld(4'd0);
        cyc(1, 0, 0, 0, 0); idle(5);
        cyc(0, 1, 0, 0, 0); idle(3);
        expect_time("pause_0009", 16'h0009);
        cyc(1, 0, 0, 0, 0); idle(3);
        expect_time("resume_hold", 16'h0009);
        idle(1);
        expect_time("resume_0008", 16'h0008);

        // Rejected commands and keypad entries.
        cyc(0, 0, 1, 0, 0); ld(4'd2);
        cyc(1, 1, 0, 0, 0); idle(1);
        cyc(0, 0, 1, 0, 0); cyc(1, 0, 0, 0, 0); idle(1);
        ld(4'd12); ld(4'd7); ld(4'd3);
        expect_time("reject_loads", 16'h0007);
        cyc(0, 0, 1, 0, 0); ld(4'd5); cyc(1, 0, 0, 0, 0); ld(4'd1); idle(1);

        // Asynchronous reset mid-run at 00:05.
        cyc(0, 0, 1, 0, 0); ld(4'd5); cyc(1, 0, 0, 0, 0); idle(2);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_mag_on", int'(mag_on), 0);
        check("async_timer_done", int'(timer_done), 1);
        check("async_time", int'({min_tens, min_units, sec_tens, sec_units}), 0);
        m_reset();
        @(negedge clk);
        #1;
        resetn = 1'b1;

        // Clear on the tick cycle: no expiry pulse.
        ld(4'd1); base = dp_seen;
        cyc(1, 0, 0, 0, 0); idle(3); cyc(0, 0, 1, 0, 0); idle(2);
        check("clear_no_pulse", dp_seen - base, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 99);
            logic [3:0] dg = 4'($urandom_range(0, 15));
            if (r < 2)       cyc(0, 0, 1, 0, 0);
            else if (r < 5)  cyc(0, 1, 0, 0, 0);
            else if (r < 12) cyc(1, 0, 0, 0, 0);
            else if (r < 14) cyc(1, 1, 0, 1, dg);
            else if (r < 40) cyc(0, 0, 0, 1, dg);
            else             idle(1);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
